// File: rtl/boot_loader_ctrl_pkg.sv
// Shared constants for the boot loader: FSM state codes and error codes.
// Also holds a small helper that tells whether a state is loading a program.
package boot_loader_ctrl_pkg;

   localparam logic [2:0] bl_idle  = 3'd0;
   localparam logic [2:0] bl_len   = 3'd1;
   localparam logic [2:0] bl_load  = 3'd2;
   localparam logic [2:0] bl_csum  = 3'd3;
   localparam logic [2:0] bl_run   = 3'd4;
   localparam logic [2:0] bl_fault = 3'd5;

   localparam logic [1:0] bl_err_none = 2'b00;
   localparam logic [1:0] bl_err_len  = 2'b01;
   localparam logic [1:0] bl_err_csum = 2'b10;
   localparam logic [1:0] bl_err_wdog = 2'b11;

   function automatic logic bl_is_loading(input logic [2:0] state);
      return (state == bl_len) || (state == bl_load) || (state == bl_csum);
   endfunction

endpackage

// File: rtl/boot_loader_ctrl_wdog.sv
// CPU run-budget counter: cleared outside RUN, counts while enabled and flags
// the last permitted cycle. A zero limit never expires.
module boot_wdog #(
   parameter int wdog_width = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [wdog_width-1:0] limit,
   output logic                  expire
);

   logic [wdog_width-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + wdog_width'(1);
      end
   end

   assign expire = enable && (limit != '0) && (count_reg == (limit - wdog_width'(1)));

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader: streams a length-prefixed, checksummed program into memory while
// holding the CPU in reset, then hands the memory port to the CPU under a watchdog.
module boot_loader_ctrl
   import boot_loader_ctrl_pkg::*;
#(
   parameter int addr_width = 8,
   parameter int data_width = 8,
   parameter int wdog_width = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [data_width-1:0] in_data,
   output logic                  in_ready,
   input  logic [wdog_width-1:0] wdog_limit,
   output logic                  cpu_rst,
   input  logic                  cpu_write,
   input  logic [addr_width-1:0] cpu_addr,
   input  logic [data_width-1:0] cpu_wdata,
   output logic [data_width-1:0] cpu_rdata,
   output logic                  mem_write,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_wdata,
   input  logic [data_width-1:0] mem_rdata,
   output logic                  busy,
   output logic                  running,
   output logic [1:0]            err
);

   generate
      if (data_width > addr_width) begin : g_width_check
         $error("boot_loader_ctrl: data_width must not exceed addr_width");
      end
   endgenerate

   logic [2:0]            state_reg, state_next;
   logic [data_width-1:0] len_reg, len_next;
   logic [data_width-1:0] sum_reg, sum_next;
   logic [addr_width-1:0] ptr_reg, ptr_next;
   logic [1:0]            err_reg, err_next;
   logic                  cpu_rst_reg;
   logic                  accept;
   logic                  wdog_expire;
   logic [addr_width-1:0] last_ptr;

   assign busy     = bl_is_loading(state_reg);
   assign in_ready = busy;
   assign running  = (state_reg == bl_run);
   assign accept   = in_valid && in_ready;
   assign last_ptr = addr_width'(len_reg) - addr_width'(1);
   assign cpu_rst  = cpu_rst_reg;
   assign err      = err_reg;

   boot_wdog #(
      .wdog_width (wdog_width)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_reg != bl_run),
      .enable (state_reg == bl_run),
      .limit  (wdog_limit),
      .expire (wdog_expire)
   );

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      sum_next   = sum_reg;
      ptr_next   = ptr_reg;
      err_next   = err_reg;
      case (state_reg)
         bl_idle, bl_fault: begin
            if (start) begin
               state_next = bl_len;
               err_next   = bl_err_none;
            end
         end
         bl_len: begin
            if (accept) begin
               if (in_data == '0) begin
                  state_next = bl_fault;
                  err_next   = bl_err_len;
               end else begin
                  len_next   = in_data;
                  ptr_next   = '0;
                  sum_next   = '0;
                  state_next = bl_load;
               end
            end
         end
         bl_load: begin
            if (accept) begin
               ptr_next = ptr_reg + addr_width'(1);
               sum_next = sum_reg + in_data;
               if (ptr_reg == last_ptr) begin
                  state_next = bl_csum;
               end
            end
         end
         bl_csum: begin
            if (accept) begin
               if (in_data == sum_reg) begin
                  state_next = bl_run;
               end else begin
                  state_next = bl_fault;
                  err_next   = bl_err_csum;
               end
            end
         end
         bl_run: begin
            // A restart takes priority over a watchdog expiry in the same cycle.
            if (start) begin
               state_next = bl_len;
               err_next   = bl_err_none;
            end else if (wdog_expire) begin
               state_next = bl_fault;
               err_next   = bl_err_wdog;
            end
         end
         default: state_next = bl_idle;
      endcase
   end

   always_comb begin
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      if (state_reg == bl_load) begin
         mem_write = in_valid;
         mem_addr  = ptr_reg;
         mem_wdata = in_data;
      end else if (state_reg == bl_run) begin
         mem_write = cpu_write;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         cpu_rdata = mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= bl_idle;
         len_reg     <= '0;
         sum_reg     <= '0;
         ptr_reg     <= '0;
         err_reg     <= bl_err_none;
         cpu_rst_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         len_reg     <= len_next;
         sum_reg     <= sum_next;
         ptr_reg     <= ptr_next;
         err_reg     <= err_next;
         cpu_rst_reg <= (state_next != bl_run);
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: directed scenarios plus randomized loads checked
// against a byte-list / checksum reference and an attached behavioural memory.
module tb_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [15:0] wdog_limit;
   logic        cpu_rst;
   logic        cpu_write;
   logic [7:0]  cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        mem_write;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        running;
   logic [1:0]  err;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   int          checks = 0;
   int          passed = 0;

   boot_loader_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wdog_limit (wdog_limit),
      .cpu_rst    (cpu_rst),
      .cpu_write  (cpu_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .running    (running),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end
   assign mem_rdata = mem[mem_addr];

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         #1;
         check("gap_no_write", mem_write, 0);
         tick();
      end
      in_data = '0;
   endtask

   task automatic send_chk(input string tag, input logic [7:0] b,
                           input logic exp_wr, input logic [7:0] exp_addr);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      check({tag, "_ready"}, in_ready, 1);
      check({tag, "_wr"}, mem_write, exp_wr);
      if (exp_wr) begin
         check({tag, "_addr"}, mem_addr, exp_addr);
         check({tag, "_wdata"}, mem_wdata, b);
         ref_mem[exp_addr] = b;
      end
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_rst"}, cpu_rst, 1);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_running"}, running, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_mem_write"}, mem_write, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 0);
   endtask

   // Count out-of-reset cycles from the current (first RUN) cycle, capped.
   task automatic count_run(input int cap, output int cycles);
      cycles = 0;
      while (!cpu_rst && cycles < cap) begin
         cycles++;
         tick();
      end
   endtask

   task automatic rand_load(input int iter);
      int         len;
      int         limit;
      int         cycles;
      int         exp_cycles;
      bit         good;
      logic [7:0] sum;
      logic [7:0] chk;
      logic [7:0] b;
      len   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      limit = $urandom_range(0, 6);
      wdog_limit = 16'(limit);
      pulse_start();
      check("rnd_in_len", busy, 1);
      gap($urandom_range(0, 2));
      send_chk("rnd_len", 8'(len), 1'b0, 8'h00);
      if (len == 0) begin
         check("rnd_zero_err", err, 1);
         check("rnd_zero_cpu_rst", cpu_rst, 1);
         return;
      end
      sum = '0;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         gap($urandom_range(0, 2));
         send_chk("rnd_byte", b, 1'b1, 8'(i));
         sum = sum + b;
      end
      good = ($urandom_range(0, 3) != 0);
      chk  = good ? sum : sum + 8'($urandom_range(1, 255));
      gap($urandom_range(0, 2));
      send_chk("rnd_csum", chk, 1'b0, 8'h00);
      for (int i = 0; i < len; i++) check("rnd_mem", mem[i], ref_mem[i]);
      if (!good) begin
         check("rnd_bad_err", err, 2);
         check("rnd_bad_cpu_rst", cpu_rst, 1);
         check("rnd_bad_running", running, 0);
      end else begin
         check("rnd_running", running, 1);
         cpu_addr = 8'($urandom_range(0, len - 1));
         #1;
         check("rnd_rdata", cpu_rdata, ref_mem[cpu_addr]);
         exp_cycles = (limit == 0) ? 12 : limit;
         count_run(12, cycles);
         cpu_addr = '0;
         check("rnd_run_cycles", cycles, exp_cycles);
         check("rnd_run_err", err, (limit == 0) ? 0 : 3);
      end
      if (iter < 0) $display("unused");
   endtask

   initial begin
      int cycles;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      wdog_limit = '0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset_outputs("reset");

      // Nominal load; the byte offered alongside start must not be taken.
      start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      #1;
      check("idle_start_in_ready", in_ready, 0);
      tick();
      start = 1'b0; in_valid = 1'b0;
      check("len_busy", busy, 1);
      send_chk("nom_len", 8'h03, 1'b0, 8'h00);
      send_chk("nom_b0", 8'h10, 1'b1, 8'h00);
      send_chk("nom_b1", 8'h20, 1'b1, 8'h01);
      send_chk("nom_b2", 8'h30, 1'b1, 8'h02);
      check("nom_not_running_yet", running, 0);
      send_chk("nom_csum", 8'h60, 1'b0, 8'h00);
      check("nom_running", running, 1);
      check("nom_cpu_rst", cpu_rst, 0);
      check("nom_mem0", mem[0], 8'h10);
      check("nom_mem1", mem[1], 8'h20);
      check("nom_mem2", mem[2], 8'h30);
      cpu_write = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'h55;
      tick();
      cpu_write = 1'b0; ref_mem[8'h80] = 8'h55;
      check("nom_cpu_wr", mem[8'h80], 8'h55);
      cpu_addr = 8'h01;
      #1;
      check("nom_cpu_rd", cpu_rdata, 8'h20);
      cpu_addr = '0;

      // Restart from RUN.
      pulse_start();
      check("restart_cpu_rst", cpu_rst, 1);
      check("restart_busy", busy, 1);
      check("restart_err", err, 0);

      // Bad checksum.
      send_chk("bad_len", 8'h02, 1'b0, 8'h00);
      send_chk("bad_b0", 8'h01, 1'b1, 8'h00);
      send_chk("bad_b1", 8'h02, 1'b1, 8'h01);
      send_chk("bad_csum", 8'h04, 1'b0, 8'h00);
      check("bad_err", err, 2);
      check("bad_cpu_rst", cpu_rst, 1);
      check("bad_running", running, 0);
      check("bad_in_ready", in_ready, 0);
      tick();
      check("bad_err_hold", err, 2);

      // Zero length, then restart clears the error.
      pulse_start();
      send_chk("zero_len", 8'h00, 1'b0, 8'h00);
      check("zero_err", err, 1);
      check("zero_busy", busy, 0);
      pulse_start();
      check("zero_restart_err", err, 0);
      check("zero_restart_busy", busy, 1);

      // Watchdog with a 5-cycle budget.
      wdog_limit = 16'd5;
      send_chk("wd_len", 8'h01, 1'b0, 8'h00);
      send_chk("wd_b0", 8'hAA, 1'b1, 8'h00);
      send_chk("wd_csum", 8'hAA, 1'b0, 8'h00);
      count_run(50, cycles);
      check("wd_cycles", cycles, 5);
      check("wd_err", err, 3);
      check("wd_cpu_rst", cpu_rst, 1);

      // Backpressure gaps, start ignored mid-load, then reset mid-load.
      wdog_limit = '0;
      pulse_start();
      send_chk("bp_len", 8'h04, 1'b0, 8'h00);
      send_chk("bp_b0", 8'hA1, 1'b1, 8'h00);
      gap(2);
      send_chk("bp_b1", 8'hA2, 1'b1, 8'h01);
      pulse_start();
      check("bp_start_ignored", busy, 1);
      send_chk("bp_b2", 8'hA3, 1'b1, 8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("midload_rst");
      check("midload_mem0", mem[0], 8'hA1);
      check("midload_mem2", mem[2], 8'hA3);

      for (int it = 0; it < 30; it++) rand_load(it);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
